led_axi_lite_slave: RTL

LED_AXI_LITE_SLAVE -- requirements
Module: led_axi_lite_slave

---
 rtl/led_axi_lite_slave.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/led_axi_lite_slave.sv
// ---------------------------------------------------------------------------
// led_axi_lite_slave
//
// AXI4-Lite slave with four 32-bit read/write registers that drive a bank of
// LEDs, optionally blinking them.
//
//   word 0  PATTERN  LED pattern (low LED_WIDTH bits are used)
//   word 1  CTRL     bit 0 = blink_en
//   word 2  PERIOD   clock cycles per half blink period (0 = steady on)
//   word 3  SCRATCH  general-purpose storage
//
// Ports
//   s00_axi_aclk / s00_axi_reset  clock, synchronous active-high reset
//   s00_axi_aw* / w* / b*         write address, write data, write response
//   s00_axi_ar* / r*              read address, read data
//   led_out                       registered LED drive
// ---------------------------------------------------------------------------
module led_axi_lite_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int LED_WIDTH          = 8
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [LED_WIDTH-1:0]            led_out
);

    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

    // Ready outputs are held low while in reset and for the reset-release cycle.
    logic              ready_en_q, ready_en_d;
    logic              aw_full_q, aw_full_d;
    logic [1:0]        aw_idx_q, aw_idx_d;
    logic              w_full_q, w_full_d;
    logic [DW-1:0]     w_data_q, w_data_d;
    logic [STRB_W-1:0] w_strb_q, w_strb_d;
    logic              bvalid_q, bvalid_d;
    logic              rvalid_q, rvalid_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [DW-1:0]     regs_q [4];
    logic [DW-1:0]     regs_d [4];
    logic [DW-1:0]     counter_q, counter_d;
    logic              phase_q, phase_d;
    logic [LED_WIDTH-1:0] led_q, led_d;

    logic          aw_hs, w_hs, ar_hs, b_hs, r_hs, commit;
    logic [DW-1:0] wr_merged;
    logic          blink_en;
    logic [DW-1:0] period;

    // Protection bits and byte-offset address bits carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                             s00_axi_awaddr, s00_axi_araddr};

    assign s00_axi_awready = ready_en_q & ~aw_full_q & ~bvalid_q;
    assign s00_axi_wready  = ready_en_q & ~w_full_q  & ~bvalid_q;
    assign s00_axi_arready = ready_en_q & ~rvalid_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = 2'b00;
    assign led_out         = led_q;

    assign aw_hs  = s00_axi_awvalid & s00_axi_awready;
    assign w_hs   = s00_axi_wvalid  & s00_axi_wready;
    assign ar_hs  = s00_axi_arvalid & s00_axi_arready;
    assign b_hs   = bvalid_q & s00_axi_bready;
    assign r_hs   = rvalid_q & s00_axi_rready;
    // Slots stay full while bvalid is high, so ~bvalid_q makes this one-shot.
    assign commit = aw_full_q & w_full_q & ~bvalid_q;

    assign blink_en = regs_q[1][0];
    assign period   = regs_q[2];

    // Byte-lane merge of captured write data over the current register value.
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
        assign wr_merged[gi*8 +: 8] = w_strb_q[gi] ? w_data_q[gi*8 +: 8]
                                                   : regs_q[aw_idx_q][gi*8 +: 8];
    end

    always_comb begin
        ready_en_d = 1'b1;
        aw_full_d  = aw_full_q;
        aw_idx_d   = aw_idx_q;
        w_full_d   = w_full_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        regs_d     = regs_q;
        counter_d  = counter_q;
        phase_d    = phase_q;

        // Write path
        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = s00_axi_awaddr[3:2];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = s00_axi_wdata;
            w_strb_d = s00_axi_wstrb;
        end
        if (commit) begin
            regs_d[aw_idx_q] = wr_merged;
            bvalid_d         = 1'b1;
        end
        if (b_hs) begin
            bvalid_d  = 1'b0;
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end

        // Read path: regs_q is the pre-commit value, so a read landing on the
        // commit edge returns the old contents.
        if (ar_hs) begin
            rdata_d  = regs_q[s00_axi_araddr[3:2]];
            rvalid_d = 1'b1;
        end else if (r_hs) begin
            rvalid_d = 1'b0;
        end

        // Blink timer. The >= compare (not ==) makes a PERIOD shrunk below the
        // running count wrap immediately instead of running on to rollover.
        if (!blink_en || period == '0) begin
            counter_d = '0;
            phase_d   = 1'b1;
        end else if (counter_q >= period - ONE) begin
            counter_d = '0;
            phase_d   = ~phase_q;
        end else begin
            counter_d = counter_q + ONE;
        end

        led_d = phase_q ? regs_q[0][LED_WIDTH-1:0] : '0;
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_reset) begin
            ready_en_q <= 1'b0;
            aw_full_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
            counter_q  <= '0;
            phase_q    <= 1'b1;
            led_q      <= '0;
        end else begin
            ready_en_q <= ready_en_d;
            aw_full_q  <= aw_full_d;
            aw_idx_q   <= aw_idx_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            regs_q     <= regs_d;
            counter_q  <= counter_d;
            phase_q    <= phase_d;
            led_q      <= led_d;
        end
    end

endmodule
